// File: rtl/uart_tx_sched_pkg.sv
// Shared types and frame constants for the UART telemetry/echo scheduler.
// UART_TX_FRAME_CHECKSUM_EN appends a modulo-256 checksum byte to each frame.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_ECHO  = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hFF;
  localparam logic [7:0] PAD_BYTE  = 8'h00;

`ifdef UART_TX_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 17;
`else
  localparam int FRAME_LEN = 16;
`endif

  localparam logic [4:0] FRAME_END = 5'(FRAME_LEN);

  function automatic logic [7:0] frame_byte(input logic [4:0] idx,
                                            input logic [11:0] ch1,
                                            input logic [11:0] ch2);
    logic [7:0] b;
    b = PAD_BYTE;
    case (idx)
      5'd0, 5'd3, 5'd6, 5'd11, 5'd14: b = SYNC_BYTE;
      5'd4:  b = {4'h0, ch1[11:8]};
      5'd5:  b = ch1[7:0];
      5'd12: b = {4'h0, ch2[11:8]};
      5'd13: b = ch2[7:0];
`ifdef UART_TX_FRAME_CHECKSUM_EN
      // Pad bytes are zero, so only the five syncs and the channel bytes contribute.
      5'd16: b = 8'(SYNC_BYTE + SYNC_BYTE + SYNC_BYTE + SYNC_BYTE + SYNC_BYTE)
               + {4'h0, ch1[11:8]} + ch1[7:0] + {4'h0, ch2[11:8]} + ch2[7:0];
`endif
      default: b = PAD_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and registered-pointer full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Multiplexes periodic ADC telemetry frames and echoed rx bytes onto one UART tx stream.
// Define UART_TX_FRAME_CHECKSUM_EN to append a checksum byte to every frame.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int CLK_FRE     = 100,
  parameter int TICK_CYCLES = 100000000,
  parameter int ECHO_DEPTH  = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [11:0] volt_ch1,
  input  logic [11:0] volt_ch2,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        frame_busy,
  output logic        echo_drop,
  output logic [1:0]  state_dbg
);

  // tx handshake: a byte moves on a rising edge with tx_data_valid & tx_data_ready;
  // once valid rises, tx_data is frozen and valid stays high until that edge.

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  if (TICK_CYCLES < 64 || ECHO_DEPTH < 2 || CLK_FRE < 1) begin : g_bad_params
  end

  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic             tick;
  logic             pending;
  logic [4:0]       idx;
  logic [11:0]      snap_ch1;
  logic [11:0]      snap_ch2;
  logic             xfer;
  logic             start_frame;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;

  assign tick          = (period_cnt == CNT_LAST);
  assign xfer          = tx_data_valid && tx_data_ready;
  assign start_frame   = (state == S_IDLE) && pending;
  assign fifo_wr       = rx_data_valid && !fifo_full;
  assign fifo_rd       = (state == S_IDLE) && !pending && !fifo_empty;
  assign rx_data_ready = !fifo_full;
  assign frame_busy    = (state == S_FRAME);
  assign state_dbg     = state;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (ECHO_DEPTH)
  ) u_echo_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_en   (fifo_wr),
    .wr_data (rx_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      period_cnt    <= '0;
      pending       <= 1'b0;
      idx           <= '0;
      snap_ch1      <= '0;
      snap_ch2      <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      echo_drop     <= 1'b0;
    end else begin
      period_cnt <= tick ? '0 : period_cnt + 1'b1;
      // A tick landing on the frame-start cycle re-arms pending for the next frame.
      pending    <= tick || (pending && !start_frame);
      echo_drop  <= rx_data_valid && fifo_full;

      case (state)
        S_IDLE: begin
          if (pending) begin
            state         <= S_FRAME;
            snap_ch1      <= volt_ch1;
            snap_ch2      <= volt_ch2;
            idx           <= 5'd1;
            tx_data       <= frame_byte(5'd0, volt_ch1, volt_ch2);
            tx_data_valid <= 1'b1;
          end else if (!fifo_empty) begin
            state         <= S_ECHO;
            tx_data       <= fifo_rd_data;
            tx_data_valid <= 1'b1;
          end
        end
        S_FRAME: begin
          if (xfer) begin
            if (idx == FRAME_END) begin
              state         <= S_IDLE;
              idx           <= '0;
              tx_data_valid <= 1'b0;
            end else begin
              tx_data <= frame_byte(idx, snap_ch1, snap_ch2);
              idx     <= idx + 5'd1;
            end
          end
        end
        S_ECHO: begin
          if (xfer) begin
            state         <= S_IDLE;
            tx_data_valid <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          tx_data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: frame content, stalls, echo ordering, drops, reset abort.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [11:0] volt_ch1;
  logic [11:0] volt_ch2;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic        frame_busy;
  logic        echo_drop;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;

  logic [7:0] got_q[$];
  logic       busy_q[$];
  logic [7:0] exp_q[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  localparam int FLEN =
`ifdef UART_TX_FRAME_CHECKSUM_EN
    17;
`else
    16;
`endif

  uart_tx_scheduler #(
    .CLK_FRE     (100),
    .TICK_CYCLES (200),
    .ECHO_DEPTH  (4)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .volt_ch1      (volt_ch1),
    .volt_ch2      (volt_ch2),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .frame_busy    (frame_busy),
    .echo_drop     (echo_drop),
    .state_dbg     (state_dbg)
  );

  // Clock and stepping
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor: records transfers, counts drop pulses, checks stall stability
  always @(negedge sys_clk) begin
    if (!sys_rst && tx_data_valid && tx_data_ready) begin
      got_q.push_back(tx_data);
      busy_q.push_back(frame_busy);
    end
    if (!sys_rst && echo_drop) drop_cnt++;
    if (!sys_rst && prev_stall) begin
      chk("hold_valid", {31'd0, tx_data_valid}, 32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
    end
    prev_stall = !sys_rst && tx_data_valid && !tx_data_ready;
    prev_data  = tx_data;
  end

  // Driver/scoreboard helpers
  task automatic check_tick_latency(input string tag);
    bit seen = 1'b0;
    step(199);
    chk({tag, "_idle_before_tick"}, {31'd0, frame_busy}, 32'd0);
    chk({tag, "_no_partial_bytes"}, got_q.size(), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1);
      if (tx_data_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_first_byte_latency"}, {31'd0, seen}, 32'd1);
    chk({tag, "_first_byte"}, {24'd0, tx_data}, 32'hFF);
    chk({tag, "_busy"}, {31'd0, frame_busy}, 32'd1);
  endtask

  task automatic wait_got(input int n, input int max_cycles, input string tag);
    int c = 0;
    while (got_q.size() < n && c < max_cycles) begin
      step(1);
      c++;
    end
    chk({tag, "_count"}, got_q.size(), n);
  endtask

  task automatic compare_got(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    int  sent;
    bit  snapped;
    int  c;

    sys_rst       = 1'b1;
    volt_ch1      = 12'h5A3;
    volt_ch2      = 12'h0F1;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    tx_data_ready = 1'b0;
    step(3);

    chk("rst_tx_valid", {31'd0, tx_data_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_frame_busy", {31'd0, frame_busy}, 32'd0);
    chk("rst_echo_drop", {31'd0, echo_drop}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_data_ready}, 32'd1);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);

    // Basic frame with ready held high
    tx_data_ready = 1'b1;
    sys_rst = 1'b0;
    check_tick_latency("t1");
    exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h05, 8'hA3, 8'hFF, 8'h00,
              8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hF1, 8'hFF, 8'h00};
`ifdef UART_TX_FRAME_CHECKSUM_EN
    exp_q.push_back(8'h94);
`endif
    wait_got(exp_q.size(), 60, "t1");
    compare_got("t1");
    step(2);
    chk("t1_idle_after", {31'd0, frame_busy}, 32'd0);
    chk("t1_valid_after", {31'd0, tx_data_valid}, 32'd0);

    // Random ready, snapshot, three rx bytes injected mid-frame
    got_q.delete();
    busy_q.delete();
    volt_ch1 = 12'h123;
    volt_ch2 = 12'hABC;
    exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h23, 8'hFF, 8'h00,
              8'h00, 8'h00, 8'h00, 8'hFF, 8'h0A, 8'hBC, 8'hFF, 8'h00};
`ifdef UART_TX_FRAME_CHECKSUM_EN
    exp_q.push_back(8'hE5);
`endif
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    sent = 0;
    snapped = 1'b0;
    for (c = 0; c < 500 && got_q.size() < exp_q.size(); c++) begin
      tx_data_ready = 1'($urandom_range(0, 1));
      if (frame_busy && !snapped) begin
        volt_ch1 = 12'hDEF;
        volt_ch2 = 12'h321;
        snapped  = 1'b1;
      end
      if (frame_busy && got_q.size() >= 4 && sent < 3) begin
        rx_data_valid = 1'b1;
        rx_data       = 8'(8'h41 + sent);
        sent++;
      end else begin
        rx_data_valid = 1'b0;
      end
      step(1);
    end
    rx_data_valid = 1'b0;
    tx_data_ready = 1'b1;
    wait_got(exp_q.size(), 100, "t2");
    compare_got("t2");
    for (int i = 0; i < exp_q.size() && i < busy_q.size(); i++)
      chk($sformatf("t2_busy%0d", i), {31'd0, busy_q[i]}, (i < FLEN) ? 32'd1 : 32'd0);

    // Frame stalled by ready low; six rx bytes into a 4-deep echo FIFO
    got_q.delete();
    busy_q.delete();
    tx_data_ready = 1'b0;
    volt_ch1 = 12'hFFF;
    volt_ch2 = 12'h000;
    c = 0;
    while (!frame_busy && c < 400) begin
      step(1);
      c++;
    end
    chk("t3_frame_start", {31'd0, frame_busy}, 32'd1);
    drop_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      rx_data_valid = 1'b1;
      rx_data       = 8'(8'hA0 + i);
      step(1);
      if (i == 2) chk("t3_ready_high_at3", {31'd0, rx_data_ready}, 32'd1);
      if (i == 3) chk("t3_ready_low_at4", {31'd0, rx_data_ready}, 32'd0);
    end
    rx_data_valid = 1'b0;
    step(2);
    chk("t3_drop_pulses", drop_cnt, 32'd2);
    chk("t3_drop_cleared", {31'd0, echo_drop}, 32'd0);
    chk("t3_stalled_byte", {24'd0, tx_data}, 32'hFF);
    chk("t3_nothing_sent", got_q.size(), 32'd0);
    exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h00,
              8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
`ifdef UART_TX_FRAME_CHECKSUM_EN
    exp_q.push_back(8'h09);
`endif
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    tx_data_ready = 1'b1;
    wait_got(exp_q.size(), 100, "t3");
    compare_got("t3");
    step(5);
    chk("t3_no_extra_echo", got_q.size(), exp_q.size());
    chk("t3_ready_restored", {31'd0, rx_data_ready}, 32'd1);

    // Pending tick and queued echo byte: frame goes before the queued byte
    got_q.delete();
    busy_q.delete();
    tx_data_ready = 1'b0;
    volt_ch1 = 12'h800;
    volt_ch2 = 12'h7FE;
    rx_data_valid = 1'b1;
    rx_data = 8'h55;
    step(1);
    rx_data = 8'h66;
    step(1);
    rx_data_valid = 1'b0;
    step(205);
    chk("t4_echo_stalled", {30'd0, state_dbg}, 32'd2);
    chk("t4_echo_byte", {24'd0, tx_data}, 32'h55);
    exp_q = '{8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h08, 8'h00, 8'hFF, 8'h00,
              8'h00, 8'h00, 8'h00, 8'hFF, 8'h07, 8'hFE, 8'hFF, 8'h00};
`ifdef UART_TX_FRAME_CHECKSUM_EN
    exp_q.push_back(8'h08);
`endif
    exp_q.push_back(8'h66);
    tx_data_ready = 1'b1;
    wait_got(exp_q.size(), 100, "t4");
    compare_got("t4");

    // Reset while frame byte 7 is on offer; next frame restarts from byte 0
    got_q.delete();
    busy_q.delete();
    c = 0;
    while (got_q.size() < 7 && c < 450) begin
      step(1);
      c++;
    end
    chk("t5_reached_byte7", got_q.size(), 32'd7);
    chk("t5_busy_at_byte7", {31'd0, frame_busy}, 32'd1);
    sys_rst = 1'b1;
    tx_data_ready = 1'b0;
    step(1);
    chk("t5_rst_tx_valid", {31'd0, tx_data_valid}, 32'd0);
    chk("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("t5_rst_frame_busy", {31'd0, frame_busy}, 32'd0);
    chk("t5_rst_echo_drop", {31'd0, echo_drop}, 32'd0);
    chk("t5_rst_rx_ready", {31'd0, rx_data_ready}, 32'd1);
    chk("t5_rst_state", {30'd0, state_dbg}, 32'd0);
    got_q.delete();
    busy_q.delete();
    volt_ch1 = 12'h001;
    volt_ch2 = 12'hF00;
    tx_data_ready = 1'b1;
    sys_rst = 1'b0;
    check_tick_latency("t5");
    exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00,
              8'h00, 8'h00, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'hFF, 8'h00};
`ifdef UART_TX_FRAME_CHECKSUM_EN
    exp_q.push_back(8'h0B);
`endif
    wait_got(exp_q.size(), 60, "t5");
    compare_got("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
